hazard_unit: RTL

Pipeline hazard unit for the five-stage ARM core. Consumes the per-stage control status the controller publishes (RegWriteM/W, MemtoRegE, PCWrPendingF, PCSrcW, BranchTakenE, ALUControlE) plus register addresses from the datapath. Returns the stall, flush and forwarding controls, including the FlushE the controller consumes. It also sequences the multi-cycle divider occupancy of Execute (UDIV/SDIV) with an internal counter/FSM, and tracks D/E valid bits.

---
 rtl/hazard_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding control for the five-stage ARM core.
// It also sequences the multi-cycle divider's occupancy of Execute and tracks
// the Decode and Execute valid bits.
//
// Ports:
//   clk, reset                     clock; asynchronous active-high reset
//   RA1D, RA2D                     source registers of the instruction in Decode
//   RA1E, RA2E                     source registers of the instruction in Execute
//   WA3E, WA3M, WA3W               destination registers in Execute, Memory and Writeback
//   RegWriteM, RegWriteW           gated register-write enables in Memory and Writeback
//   MemtoRegE                      a load is in Execute
//   PCWrPendingF                   a PC write is in flight in Decode, Execute or Memory
//   PCSrcW                         a PC write is retiring in Writeback
//   BranchTakenE                   a taken branch was resolved in Execute
//   ALUControlE                    ALU operation in Execute
//   StallF, StallD, StallE         hold the fetch PC, the D register, the E register
//   FlushD, FlushE                 clear the D register, the E register
//   BubbleM                        load a bubble into the M register
//   ForwardAE, ForwardBE           operand source: 00 register file, 01 ResultW, 10 ALUResultM
//   DivBusyE                       the divider is holding Execute
module hazard_unit #(
  parameter int unsigned DIV_CYCLES       = 16,
  parameter int unsigned ALUCONTROL_WIDTH = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [3:0]                  RA1D,
  input  logic [3:0]                  RA2D,
  input  logic [3:0]                  RA1E,
  input  logic [3:0]                  RA2E,
  input  logic [3:0]                  WA3E,
  input  logic [3:0]                  WA3M,
  input  logic [3:0]                  WA3W,
  input  logic                        RegWriteM,
  input  logic                        RegWriteW,
  input  logic                        MemtoRegE,
  input  logic                        PCWrPendingF,
  input  logic                        PCSrcW,
  input  logic                        BranchTakenE,
  input  logic [ALUCONTROL_WIDTH-1:0] ALUControlE,
  output logic                        StallF,
  output logic                        StallD,
  output logic                        StallE,
  output logic                        FlushD,
  output logic                        FlushE,
  output logic                        BubbleM,
  output logic [1:0]                  ForwardAE,
  output logic [1:0]                  ForwardBE,
  output logic                        DivBusyE
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DIV_CYCLES - 2);
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_UDIV = ALUCONTROL_WIDTH'(5'b01110);
  localparam logic [ALUCONTROL_WIDTH-1:0] ALU_SDIV = ALUCONTROL_WIDTH'(5'b01111);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_valid_d;
  logic             r_valid_e;

  logic w_kill;
  logic w_div_e;
  logic w_div_busy;
  logic w_ldr_stall;
  logic w_stall_f;
  logic w_stall_d;
  logic w_stall_e;
  logic w_flush_d;
  logic w_flush_e;

  // Forward select for one Execute operand; Memory wins over Writeback, r15 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [3:0] ra, input logic rw_m,
                                         input logic [3:0] wa_m, input logic rw_w,
                                         input logic [3:0] wa_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (rw_m && (ra == wa_m) && (wa_m != 4'd15)) begin
      sel = 2'b10;
    end else if (rw_w && (ra == wa_w) && (wa_w != 4'd15)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign w_kill      = PCSrcW | BranchTakenE;
  assign w_div_e     = r_valid_e & ((ALUControlE == ALU_UDIV) | (ALUControlE == ALU_SDIV));
  assign w_ldr_stall = r_valid_e & MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign w_stall_f   = (w_ldr_stall | PCWrPendingF | w_div_busy) & ~PCSrcW & ~BranchTakenE;
  assign w_stall_d   = w_ldr_stall | w_div_busy;
  assign w_stall_e   = w_div_busy;
  assign w_flush_d   = PCWrPendingF | w_kill;
  assign w_flush_e   = w_ldr_stall | w_kill;

  // Divider FSM next state; Cnt counts the remaining busy cycles after the first.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_div_busy  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_div_busy = w_div_e & ~w_kill;
        if (w_div_e && !w_kill) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = CNT_START;
        end
      end
      S_BUSY: begin
        w_div_busy = ~w_kill & (r_cnt != '0);
        if (w_kill) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          // Last cycle of the divide: it leaves Execute at this edge.
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Divider FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Valid bits follow the pipeline registers; flush beats stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_d <= 1'b0;
      r_valid_e <= 1'b0;
    end else begin
      if (w_flush_d)      r_valid_d <= 1'b0;
      else if (!w_stall_d) r_valid_d <= 1'b1;

      if (w_flush_e)      r_valid_e <= 1'b0;
      else if (!w_stall_e) r_valid_e <= r_valid_d;
    end
  end

  // Outputs; reset forces flushes so the pipeline registers clear alongside this block.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    BubbleM   = 1'b0;
    DivBusyE  = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!reset) begin
      StallF    = w_stall_f;
      StallD    = w_stall_d;
      StallE    = w_stall_e;
      FlushD    = w_flush_d;
      FlushE    = w_flush_e;
      BubbleM   = w_div_busy;
      DivBusyE  = w_div_busy;
      ForwardAE = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
      ForwardBE = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);
    end
  end

endmodule
